// File: rtl/instr_encoder.sv
// instr_encoder: packs move/jump requests into IR bytes and queues them for fetch.
// Define INSTR_ENCODER_CHECK_EN to drop unimplemented-field requests and flag them on err.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_dest,
  input  logic [2:0]                 req_src,
  input  logic                       req_sub,
  input  logic                       req_carry,
  input  logic [7:0]                 req_imm,
  output logic                       ir_valid,
  output logic [7:0]                 ir_data,
  input  logic                       ir_take,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] room_lim = (AW+1)'(DEPTH - 2);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic accept, illegal, pop;
  logic [1:0] n_push;
  logic [7:0] op;
`ifdef INSTR_ENCODER_CHECK_EN
  assign illegal = (req_dest == 3'd7) || (req_src == 3'd1);
`else
  assign illegal = 1'b0;
`endif
  assign op = {req_carry, req_dest, req_sub, req_src};
  assign req_ready = cnt_q <= room_lim;
  assign accept = req_valid & req_ready;
  assign pop = ir_take & (cnt_q != '0);
  assign n_push = (accept && !illegal) ? ((req_src == 3'd0) ? 2'd2 : 2'd1) : 2'd0;
  assign ir_valid = cnt_q != '0;
  assign ir_data = ir_valid ? mem_q[rd_q] : 8'h00;
  assign level = cnt_q;
  assign err = err_q;
  always_comb begin
    mem_d = mem_q;
    if (n_push != 2'd0) mem_d[wr_q] = op;
    if (n_push == 2'd2) mem_d[wr_q + AW'(1)] = req_imm;
    wr_d = wr_q + AW'(n_push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(n_push) - (AW+1)'(pop);
    err_d = err_q | (accept & illegal);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // storage needs no reset: ir_data is masked while the queue is empty
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of encoding, queueing, wrap-around and reset.
module tb_instr_encoder;
`ifdef INSTR_ENCODER_CHECK_EN
  localparam bit chk_en = 1'b1;
`else
  localparam bit chk_en = 1'b0;
`endif
  logic clk, reset, req_valid, req_ready, req_sub, req_carry, ir_valid, ir_take, err;
  logic [2:0] req_dest, req_src, level;
  logic [7:0] req_imm, ir_data;
  int n_cmp = 0;
  int n_err = 0;

  instr_encoder #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_src(req_src), .req_sub(req_sub), .req_carry(req_carry),
    .req_imm(req_imm), .ir_valid(ir_valid), .ir_data(ir_data), .ir_take(ir_take),
    .level(level), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [2:0] d, input logic [2:0] s,
                     input logic sb, input logic c, input logic [7:0] imm, input logic t);
    req_valid = v; req_dest = d; req_src = s; req_sub = sb; req_carry = c; req_imm = imm;
    ir_take = t;
    @(posedge clk);
    #1;
    req_valid = 1'b0; ir_take = 1'b0;
  endtask

  task automatic state(input string tag, input logic v, input logic [7:0] d,
                       input logic [2:0] l, input logic r);
    chk({tag, ".valid"}, 32'(ir_valid), 32'(v));
    chk({tag, ".data"}, 32'(ir_data), 32'(d));
    chk({tag, ".level"}, 32'(level), 32'(l));
    chk({tag, ".ready"}, 32'(req_ready), 32'(r));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; ir_take = 1'b0;
    req_dest = '0; req_src = '0; req_sub = 1'b0; req_carry = 1'b0; req_imm = '0;
    #2;
    state("rst", 1'b0, 8'h00, 3'd0, 1'b1);
    chk("rst.err", 32'(err), 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    cyc(1, 3'd2, 3'd4, 0, 0, 8'h00, 0);
    state("mov", 1'b1, 8'h24, 3'd1, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    state("mov.take", 1'b0, 8'h00, 3'd0, 1'b1);

    cyc(1, 3'd1, 3'd0, 0, 1, 8'h10, 0);
    state("imm", 1'b1, 8'h90, 3'd2, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    state("imm.t1", 1'b1, 8'h10, 3'd1, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    state("imm.t2", 1'b0, 8'h00, 3'd0, 1'b1);

    cyc(1, 3'd3, 3'd2, 0, 0, 8'h00, 0);
    cyc(1, 3'd4, 3'd5, 1, 0, 8'h00, 0);
    state("fill2", 1'b1, 8'h32, 3'd2, 1'b1);
    cyc(1, 3'd5, 3'd6, 0, 1, 8'h00, 0);
    state("fill3", 1'b1, 8'h32, 3'd3, 1'b0);
    cyc(1, 3'd6, 3'd3, 0, 0, 8'h00, 0);
    state("held", 1'b1, 8'h32, 3'd3, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    state("drain1", 1'b1, 8'h4D, 3'd2, 1'b1);

    cyc(1, 3'd0, 3'd0, 1, 0, 8'hA5, 1);
    state("pushpop", 1'b1, 8'hD6, 3'd3, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    state("order1", 1'b1, 8'h08, 3'd2, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    state("order2", 1'b1, 8'hA5, 3'd1, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    state("order3", 1'b0, 8'h00, 3'd0, 1'b1);

    // streaming push+take: first take hits an empty queue and must be ignored
    for (int i = 0; i < 7; i++) begin
      cyc(1, 3'(i), 3'd3, 0, 0, 8'h00, 1);
      state($sformatf("wrap%0d", i), 1'b1, {1'b0, 3'(i), 1'b0, 3'd3}, 3'd1, 1'b1);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    state("wrap.end", 1'b0, 8'h00, 3'd0, 1'b1);

    cyc(1, 3'd7, 3'd2, 0, 0, 8'h00, 0);
    state("q7", !chk_en, chk_en ? 8'h00 : 8'h72, chk_en ? 3'd0 : 3'd1, 1'b1);
    chk("q7.err", 32'(err), 32'(chk_en));
    if (!chk_en) cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 3'd2, 3'd4, 0, 0, 8'h00, 0);
    state("legal", 1'b1, 8'h24, 3'd1, 1'b1);
    chk("legal.err", 32'(err), 32'(chk_en));

    cyc(1, 3'd3, 3'd2, 0, 0, 8'h00, 0);
    cyc(1, 3'd4, 3'd5, 1, 0, 8'h00, 0);
    state("pre_rst", 1'b1, 8'h24, 3'd3, 1'b0);
    #2; reset = 1'b1; #1;
    state("arst", 1'b0, 8'h00, 3'd0, 1'b1);
    chk("arst.err", 32'(err), 32'd0);
    #1; reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    state("post_rst", 1'b0, 8'h00, 3'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
